// File: rtl/relogio_pkg.sv
// Shared types and helpers for the hours/minutes/seconds clock.
package relogio_pkg;

  typedef enum logic [1:0] {RUN = 2'd0, SET_HOUR = 2'd1, SET_MIN = 2'd2} mode_t;

  localparam int BCD_W = 8;

  // Two-digit BCD image of a binary value in 0..99.
  function automatic logic [BCD_W-1:0] to_bcd(input int v);
    logic [3:0] t, u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

endpackage

// File: rtl/relogio_hms_param_bcd_mod_counter.sv
// Two-digit BCD counter running 00..MOD-1 with increment and synchronous clear.
module bcd_mod_counter
  import relogio_pkg::*;
#(
  parameter int MOD = 60
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             inc,
  input  logic             clr,
  output logic [BCD_W-1:0] out,
  output logic             at_max
);

  localparam logic [BCD_W-1:0] MAX_BCD = to_bcd(MOD - 1);

  if (MOD < 2 || MOD > 99) begin : g_mod_chk
    $error("bcd_mod_counter: MOD must be in 2..99");
  end

  logic [BCD_W-1:0] nxt;

  assign at_max = (out == MAX_BCD);

  // Clear has priority so a field can be zeroed even when an increment is pending.
  always_comb begin
    nxt = out;
    if (clr)
      nxt = '0;
    else if (inc) begin
      if (at_max)
        nxt = '0;
      else if (out[3:0] == 4'd9)
        nxt = {out[7:4] + 4'd1, 4'd0};
      else
        nxt = {out[7:4], out[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) out <= '0;
    else        out <= nxt;
  end

endmodule

// File: rtl/relogio_hms_param.sv
// Time-of-day counter: cascaded BCD fields, end-of-day pulse and a button-driven set mode.
module relogio_hms_param
  import relogio_pkg::*;
#(
  parameter int SEC_MOD  = 60,
  parameter int MIN_MOD  = 60,
  parameter int HOUR_MOD = 24
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tick_en,
  input  logic             mode_btn,
  input  logic             inc_btn,
  output logic [BCD_W-1:0] sec_bcd,
  output logic [BCD_W-1:0] min_bcd,
  output logic [BCD_W-1:0] hour_bcd,
  output logic             day_carry,
  output logic [1:0]       mode
);

  mode_t state, state_nxt;
  logic  run_tick, set_h, set_m, sec_clr;
  logic  sec_max, min_max, hour_max;
  logic  sec_inc, min_inc, hour_inc;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= RUN;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:      if (mode_btn) state_nxt = SET_HOUR;
      SET_HOUR: if (mode_btn) state_nxt = SET_MIN;
      SET_MIN:  if (mode_btn) state_nxt = RUN;
      default:  state_nxt = RUN;
    endcase
  end

  // A mode press swallows any tick or increment arriving in the same cycle.
  assign run_tick = (state == RUN)      && tick_en && !mode_btn;
  assign set_h    = (state == SET_HOUR) && inc_btn && !mode_btn;
  assign set_m    = (state == SET_MIN)  && inc_btn && !mode_btn;
  assign sec_clr  = (state == SET_MIN)  && mode_btn;

  assign sec_inc  = run_tick;
  assign min_inc  = (run_tick && sec_max) || set_m;
  assign hour_inc = (run_tick && sec_max && min_max) || set_h;

  bcd_mod_counter #(.MOD(SEC_MOD)) u_sec (
    .clk(clk), .reset(reset), .inc(sec_inc), .clr(sec_clr),
    .out(sec_bcd), .at_max(sec_max)
  );

  bcd_mod_counter #(.MOD(MIN_MOD)) u_min (
    .clk(clk), .reset(reset), .inc(min_inc), .clr(1'b0),
    .out(min_bcd), .at_max(min_max)
  );

  bcd_mod_counter #(.MOD(HOUR_MOD)) u_hour (
    .clk(clk), .reset(reset), .inc(hour_inc), .clr(1'b0),
    .out(hour_bcd), .at_max(hour_max)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) day_carry <= 1'b0;
    else        day_carry <= run_tick && sec_max && min_max && hour_max;
  end

  assign mode = state;

endmodule

// File: tb/tb_relogio_hms_param.sv
// Bench: a 24-hour and a 12-hour clock share stimulus and are checked against a seconds-of-day model.
module tb_relogio_hms_param;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic tick_en = 1'b0, mode_btn = 1'b0, inc_btn = 1'b0;

  logic [7:0] sec_a, min_a, hour_a, sec_b, min_b, hour_b;
  logic       dc_a, dc_b;
  logic [1:0] mode_a, mode_b;

  int checks = 0;
  int errors = 0;
  bit started = 0;

  localparam int HMOD[2] = '{24, 12};

  always #5 clk = ~clk;

  relogio_hms_param #(.SEC_MOD(60), .MIN_MOD(60), .HOUR_MOD(24)) dut_a (
    .clk(clk), .reset(reset), .tick_en(tick_en), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .sec_bcd(sec_a), .min_bcd(min_a), .hour_bcd(hour_a), .day_carry(dc_a), .mode(mode_a)
  );

  relogio_hms_param #(.SEC_MOD(60), .MIN_MOD(60), .HOUR_MOD(12)) dut_b (
    .clk(clk), .reset(reset), .tick_en(tick_en), .mode_btn(mode_btn), .inc_btn(inc_btn),
    .sec_bcd(sec_b), .min_bcd(min_b), .hour_bcd(hour_b), .day_carry(dc_b), .mode(mode_b)
  );

  // Model: time kept as plain integers, advanced as seconds-of-day.
  int ms[2], mm[2], mh[2];
  int mmode;
  bit mdc[2];

  function automatic int next_tod(input int h, input int m, input int s, input int hm);
    return ((h * 60 + m) * 60 + s + 1) % (hm * 3600);
  endfunction

  function automatic logic [7:0] bcd(input int v);
    logic [7:0] r;
    r = 8'((v / 10) * 16 + (v % 10));
    return r;
  endfunction

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      mmode <= 0;
      for (int k = 0; k < 2; k++) begin
        ms[k] <= 0; mm[k] <= 0; mh[k] <= 0; mdc[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) mdc[k] <= 1'b0;
      case (mmode)
        0: if (mode_btn) mmode <= 1;
           else if (tick_en)
             for (int k = 0; k < 2; k++) begin
               ms[k]  <= next_tod(mh[k], mm[k], ms[k], HMOD[k]) % 60;
               mm[k]  <= (next_tod(mh[k], mm[k], ms[k], HMOD[k]) / 60) % 60;
               mh[k]  <= next_tod(mh[k], mm[k], ms[k], HMOD[k]) / 3600;
               mdc[k] <= (next_tod(mh[k], mm[k], ms[k], HMOD[k]) == 0);
             end
        1: if (mode_btn) mmode <= 2;
           else if (inc_btn)
             for (int k = 0; k < 2; k++) mh[k] <= (mh[k] + 1) % HMOD[k];
        default: if (mode_btn) begin
             mmode <= 0;
             for (int k = 0; k < 2; k++) ms[k] <= 0;
           end else if (inc_btn)
             for (int k = 0; k < 2; k++) mm[k] <= (mm[k] + 1) % 60;
      endcase
    end
  end

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      chk("sec_a",  sec_a,  bcd(ms[0]));
      chk("min_a",  min_a,  bcd(mm[0]));
      chk("hour_a", hour_a, bcd(mh[0]));
      chk("dc_a",   {7'd0, dc_a}, {7'd0, mdc[0]});
      chk("mode_a", {6'd0, mode_a}, 8'(mmode));
      chk("sec_b",  sec_b,  bcd(ms[1]));
      chk("min_b",  min_b,  bcd(mm[1]));
      chk("hour_b", hour_b, bcd(mh[1]));
      chk("dc_b",   {7'd0, dc_b}, {7'd0, mdc[1]});
      chk("mode_b", {6'd0, mode_b}, 8'(mmode));
    end
  end

  // One cycle of stimulus: inputs valid from just after one edge until just after the next.
  task automatic cyc(input bit t, input bit mb, input bit ib);
    tick_en = t; mode_btn = mb; inc_btn = ib;
    @(posedge clk); #1;
    tick_en = 0; mode_btn = 0; inc_btn = 0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1, 0, 0);
  endtask

  task automatic incs(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 1);
  endtask

  task automatic do_reset();
    #2 reset = 0;
    #10 reset = 1;
    @(posedge clk); #1;
  endtask

  initial begin
    #1 reset = 0;
    #10 reset = 1;
    started = 1;
    @(posedge clk); #1;
    chk("rst_sec", sec_a, 8'h00);
    chk("rst_mode", {6'd0, mode_a}, 8'h00);
    chk("rst_dc", {7'd0, dc_a}, 8'h00);

    ticks(59);
    chk("t59_sec", sec_a, 8'h59);
    chk("t59_min", min_a, 8'h00);
    ticks(1);
    chk("t60_sec", sec_a, 8'h00);
    chk("t60_min", min_a, 8'h01);

    // Set sequence with simultaneous-event corners.
    do_reset();
    ticks(5);
    cyc(1, 1, 0);
    chk("mtick_mode", {6'd0, mode_a}, 8'h01);
    chk("mtick_sec", sec_a, 8'h05);
    incs(25);
    cyc(1, 0, 0);
    chk("seth_hour", hour_a, 8'h01);
    chk("seth_sec", sec_a, 8'h05);
    cyc(0, 1, 1);
    chk("minc_mode", {6'd0, mode_a}, 8'h02);
    chk("minc_hour", hour_a, 8'h01);
    incs(3);
    cyc(1, 0, 0);
    chk("setm_min", min_a, 8'h03);
    cyc(0, 1, 0);
    chk("run_mode", {6'd0, mode_a}, 8'h00);
    chk("run_sec", sec_a, 8'h00);

    // Day wrap: a -> 23:59:59, b -> 11:59:59.
    cyc(0, 1, 0); incs(22);
    cyc(0, 1, 0); incs(56);
    cyc(0, 1, 0);
    ticks(59);
    chk("pre_hour_a", hour_a, 8'h23);
    chk("pre_hour_b", hour_b, 8'h11);
    chk("pre_min_b", min_b, 8'h59);
    chk("pre_sec_a", sec_a, 8'h59);
    chk("pre_dc_a", {7'd0, dc_a}, 8'h00);
    ticks(1);
    chk("wrap_hour_a", hour_a, 8'h00);
    chk("wrap_min_a", min_a, 8'h00);
    chk("wrap_sec_a", sec_a, 8'h00);
    chk("wrap_dc_a", {7'd0, dc_a}, 8'h01);
    chk("wrap_hour_b", hour_b, 8'h00);
    chk("wrap_dc_b", {7'd0, dc_b}, 8'h01);
    cyc(0, 0, 0);
    chk("after_dc_a", {7'd0, dc_a}, 8'h00);
    chk("after_dc_b", {7'd0, dc_b}, 8'h00);
    ticks(3);

    // Asynchronous reset at 12:34:56 while in SET_MIN.
    do_reset();
    cyc(0, 1, 0); incs(12);
    cyc(0, 1, 0); incs(34);
    cyc(0, 1, 0);
    ticks(56);
    cyc(0, 1, 0); cyc(0, 1, 0);
    chk("pre_rst_hour", hour_a, 8'h12);
    chk("pre_rst_min", min_a, 8'h34);
    chk("pre_rst_sec", sec_a, 8'h56);
    chk("pre_rst_mode", {6'd0, mode_a}, 8'h02);
    #2 reset = 0;
    #1;
    chk("arst_hour", hour_a, 8'h00);
    chk("arst_min", min_a, 8'h00);
    chk("arst_sec", sec_a, 8'h00);
    chk("arst_mode", {6'd0, mode_a}, 8'h00);
    chk("arst_dc", {7'd0, dc_a}, 8'h00);
    #10 reset = 1;
    @(posedge clk); #1;
    ticks(2);

    started = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/relogio_hms_param.md
Name: relogio_hms_param

Overview:
- Parametrised hours/minutes/seconds time-of-day counter for the FPGA practice-board clock.
- Generalises a single fixed-modulus counter into three cascaded BCD counters with configurable moduli.
- Adds a registered end-of-day carry and a set-time state machine driven by debounced button pulses.
- Outputs feed the seven-segment display decoders directly.

Parameters:
- SEC_MOD, 60, seconds modulus; legal range 2..99.
- MIN_MOD, 60, minutes modulus; legal range 2..99.
- HOUR_MOD, 24, hours modulus; legal range 2..99 (12 or 24 in practice).

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- tick_en  input  1  one-cycle enable pulse, one per second of time.
- mode_btn  input  1  debounced single-cycle pulse; advances the mode FSM.
- inc_btn  input  1  debounced single-cycle pulse; increments the field being set.
- sec_bcd  output  8  seconds; [7:4] tens, [3:0] units.
- min_bcd  output  8  minutes, same BCD format.
- hour_bcd  output  8  hours, same BCD format.
- day_carry  output  1  one-cycle registered pulse on day wrap.
- mode  output  2  current FSM state; RUN=0, SET_HOUR=1, SET_MIN=2.

Behaviour:
- Reset (reset=0, asynchronous):
  - All BCD outputs = 8'h00.
  - day_carry = 0.
  - mode = RUN.
  - Reset takes effect immediately, even mid-set or mid-cascade.
- All state updates on posedge clk. Every output is a flop; there is no combinational path from inputs to outputs.
- Each field counts 0..MOD-1 in BCD:
  - Units digit wraps 9->0 with a tens increment.
  - At MOD-1 the field wraps to 00.
  - Binary-coded values never appear.
- RUN, tick_en=1: seconds increments.
  - Minutes increments in the same edge only if seconds is at SEC_MOD-1.
  - Hours increments only if both seconds and minutes are at max.
  - The whole cascade resolves in one edge, so latency is 1 cycle from tick_en.
- day_carry:
  - Set to 1 on the edge where all three fields wrap to 00 (e.g. 23:59:59 -> 00:00:00).
  - Cleared on the next edge.
  - Therefore high for exactly the cycle in which the outputs read 00:00:00 after a wrap.
  - Never asserted outside RUN.
- RUN, tick_en=0: all fields hold; day_carry=0.
- FSM transitions, taken on mode_btn=1 only:
  - RUN -> SET_HOUR.
  - SET_HOUR -> SET_MIN.
  - SET_MIN -> RUN.
- SET_HOUR / SET_MIN:
  - tick_en is ignored and time is frozen.
  - inc_btn=1 increments only the selected field, modulo its MOD.
  - No carry propagates into other fields and day_carry is not asserted.
- On the SET_MIN -> RUN edge, seconds is cleared to 00. Hours and minutes keep the values set.
- Simultaneous events:
  - mode_btn and inc_btn together: the mode transition wins and inc_btn is ignored that cycle.
  - mode_btn and tick_en together in RUN: the tick is discarded and the FSM enters SET_HOUR with the time unchanged.
- Illegal mode encoding 3: recovers to RUN on the next edge, with fields held.
- Parameter legality is checked at elaboration; an assertion error fires if any MOD < 2 or > 99.

Decomposition:
- Package relogio_pkg holds:
  - typedef enum logic [1:0] mode_t {RUN, SET_HOUR, SET_MIN}.
  - Localparam BCD_W = 8.
  - Function to_bcd(int) returning the BCD encoding of MOD-1, used for max compares.
- Sub-module bcd_mod_counter:
  - Parameter MOD.
  - Ports: clk, reset, inc, clr, out.
  - Flag at_max: combinational, true when out equals MOD-1.
- The top instantiates it three times and contains the FSM, the cascade enables and the day_carry flop.

Test Plan:
- Reset then 59 tick_en pulses -> sec_bcd=8'h59, min_bcd=8'h00; one more tick -> sec=8'h00, min=8'h01.
- From 23:59:59 (set via buttons, then 59 ticks), one tick -> outputs 00:00:00 and day_carry=1 for exactly 1 cycle, then 0.
- HOUR_MOD=12 build, hours at 8'h11, minutes and seconds at max, one tick -> hour_bcd=8'h00 and day_carry pulses.
- Set sequence: mode_btn -> mode=1; inc_btn x25 -> hour_bcd=8'h01; mode_btn; inc_btn x3 -> min_bcd=8'h03; mode_btn -> mode=0 and sec_bcd=8'h00; tick_en pulses during the set states change nothing.
- mode_btn and inc_btn in the same cycle in SET_HOUR -> mode=2 and hour_bcd unchanged; tick_en with mode_btn in RUN -> mode=1, time unchanged.
- Assert reset mid-run at 12:34:56 in SET_MIN -> all outputs 00, mode=0 and day_carry=0 without waiting for a clk edge.
